// File: rtl/movement_key_decoder_pkg.sv
// Shared definitions for the movement key decoder.
//   - PS/2 set-2 prefix and key scan codes
//   - held/active bit indices in {right,left,up,down} order
//   - FSM state encoding
//   - scan-code to key-mask lookups and the release fallback priority
package movement_key_decoder_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Letter keys, sent without a prefix
    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;

    // Arrow keys, only meaningful after E0 (bare they are keypad keys)
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    localparam int KEY_RIGHT = 3;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // One-hot key mask for a non-extended code, zero if unmapped.
    function automatic logic [3:0] map_plain(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            CODE_W:  m[KEY_UP]    = 1'b1;
            CODE_S:  m[KEY_DOWN]  = 1'b1;
            CODE_A:  m[KEY_LEFT]  = 1'b1;
            CODE_D:  m[KEY_RIGHT] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // One-hot key mask for a code that followed E0, zero if unmapped.
    function automatic logic [3:0] map_ext(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            CODE_UP:    m[KEY_UP]    = 1'b1;
            CODE_DOWN:  m[KEY_DOWN]  = 1'b1;
            CODE_LEFT:  m[KEY_LEFT]  = 1'b1;
            CODE_RIGHT: m[KEY_RIGHT] = 1'b1;
            default:    m = '0;
        endcase
        return m;
    endfunction

    // Active key after the active one is released: up > down > left > right.
    function automatic logic [3:0] fallback_active(input logic [3:0] held);
        logic [3:0] a;
        a = '0;
        if (held[KEY_UP])         a[KEY_UP]    = 1'b1;
        else if (held[KEY_DOWN])  a[KEY_DOWN]  = 1'b1;
        else if (held[KEY_LEFT])  a[KEY_LEFT]  = 1'b1;
        else if (held[KEY_RIGHT]) a[KEY_RIGHT] = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/movement_key_decoder.sv
// Movement key decoder: turns the PS/2 set-2 byte stream into held-key
// flags and a single active movement control (most recent held key).
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   scan_valid         one-cycle strobe, scan_code carries a new byte
//   scan_code[7:0]     received PS/2 byte
//   held[3:0]          {right,left,up,down} held flags
//   turn_right, turn_left, move_forward, move_backward
//                      one-hot active control (or none)
//   key_event          one-cycle pulse whenever held changes
module movement_key_decoder
    import movement_key_decoder_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [3:0] held,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic       key_event
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        active;
    logic [3:0]        plain_mask;
    logic [3:0]        ext_mask;
    logic [3:0]        make_mask;
    logic [3:0]        brk_mask;

    assign plain_mask = map_plain(scan_code);
    assign ext_mask   = map_ext(scan_code);

    // Which key (if any) this byte makes or breaks, given the prefix state.
    // Prefix bytes never map, so they produce empty masks in every state.
    always_comb begin
        make_mask = '0;
        brk_mask  = '0;
        if (scan_valid) begin
            case (state)
                ST_IDLE:    make_mask = plain_mask;
                ST_EXT:     make_mask = ext_mask;
                ST_BRK:     brk_mask  = plain_mask;
                ST_EXT_BRK: brk_mask  = ext_mask;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            held      <= '0;
            active    <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;

            if (scan_valid) begin
                cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (scan_code == PREFIX_EXT)      state <= ST_EXT;
                        else if (scan_code == PREFIX_BRK) state <= ST_BRK;
                        else                              state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (scan_code == PREFIX_BRK)      state <= ST_EXT_BRK;
                        else if (scan_code == PREFIX_EXT) state <= ST_EXT;
                        else                              state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Abandon a stale prefix; a byte on the expiry cycle takes
                // the branch above instead and is decoded normally.
                if (cnt == CNT_W'(PREFIX_TIMEOUT - 1)) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (make_mask != '0) begin
                held <= held | make_mask;
                // Typematic repeats of a held key leave everything alone.
                if ((held & make_mask) == '0) begin
                    active    <= make_mask;
                    key_event <= 1'b1;
                end
            end else if (brk_mask != '0) begin
                held <= held & ~brk_mask;
                if ((held & brk_mask) != '0)
                    key_event <= 1'b1;
                if ((active & brk_mask) != '0)
                    active <= fallback_active(held & ~brk_mask);
            end
        end
    end

    assign turn_right    = active[KEY_RIGHT];
    assign turn_left     = active[KEY_LEFT];
    assign move_forward  = active[KEY_UP];
    assign move_backward = active[KEY_DOWN];

endmodule
